// File: rtl/gearbox_unpack_if.sv
// Handshake bundle for gearbox_unpack: wide-word input stream and narrow-symbol output stream.
// Signal names are from the unpacker's point of view (slave = the unpacker itself).
interface gearbox_unpack_if #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 7
);
   localparam int NB_W = $clog2(IN_WIDTH + 1);

   logic                 valid_in;
   logic                 ready_out;
   logic [IN_WIDTH-1:0]  data_in;
   logic                 sop_in;
   logic                 eop_in;
   logic [NB_W-1:0]      nbits_in;
   logic                 valid_out;
   logic                 ready_in;
   logic [OUT_WIDTH-1:0] data_out;
   logic                 sop_out;
   logic                 eop_out;
   logic                 drop_err;

   modport slave (
      input  valid_in, data_in, sop_in, eop_in, nbits_in, ready_in,
      output ready_out, valid_out, data_out, sop_out, eop_out, drop_err
   );

   modport master (
      output valid_in, data_in, sop_in, eop_in, nbits_in, ready_in,
      input  ready_out, valid_out, data_out, sop_out, eop_out, drop_err
   );
endinterface

// File: rtl/gearbox_unpack.sv
// Width-reducing gearbox: splits IN_WIDTH-bit words (LSB first) into OUT_WIDTH-bit symbols,
// tracking packet boundaries and optionally zero-padding the trailing partial symbol.
module gearbox_unpack #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 7,
   parameter int PAD_LAST  = 1
) (
   input logic             clk,
   input logic             rst_n,
   gearbox_unpack_if.slave bus
);
   localparam int BUF_W  = IN_WIDTH + OUT_WIDTH - 1;
   localparam int NB_W   = $clog2(IN_WIDTH + 1);
   localparam int FILL_W = $clog2(BUF_W + 1);
   localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_WIDTH);
   localparam logic [FILL_W-1:0] IN_F  = FILL_W'(IN_WIDTH);
   localparam logic [NB_W-1:0]   IN_NB = NB_W'(IN_WIDTH);

   typedef enum logic {S_FILL, S_FLUSH} state_t;

   state_t             state;
   logic [BUF_W-1:0]   bit_buf;
   logic [FILL_W-1:0]  fill;
   logic               sop_pend;
   logic               pkt_emit;
   logic               drop_err_r;

   logic               is_flush;
   logic               has_sym;
   logic               has_part;
   logic               last_sym;
   logic               valid_o;
   logic               ready_o;
   logic               in_fire;
   logic               out_fire;
   logic [BUF_W-1:0]   pop_buf;
   logic [FILL_W-1:0]  pop_fill;
   logic [FILL_W-1:0]  add_fill;
   logic [BUF_W-1:0]   app_buf;

   // Number of valid bits carried by the incoming word; out-of-range counts act as a full word.
   function automatic logic [FILL_W-1:0] word_bits(input logic eop, input logic [NB_W-1:0] nb);
      if (eop && (nb != '0) && (nb <= IN_NB))
         return FILL_W'(nb);
      return IN_F;
   endfunction

   function automatic logic [IN_WIDTH-1:0] keep_low(input logic [IN_WIDTH-1:0] d,
                                                    input logic [FILL_W-1:0]   n);
      logic [IN_WIDTH-1:0] m;
      for (int i = 0; i < IN_WIDTH; i++)
         m[i] = (i < int'(n));
      return d & m;
   endfunction

   always_comb begin
      is_flush = (state == S_FLUSH);
      has_sym  = (fill >= OUT_F);
      has_part = (fill != '0) && !has_sym;
      if (PAD_LAST != 0)
         last_sym = has_part || (fill == OUT_F);
      else
         last_sym = has_sym && ((fill - OUT_F) < OUT_F);
      if (is_flush)
         valid_o = has_sym || ((PAD_LAST != 0) && has_part);
      else
         valid_o = has_sym;
      // ready_in feeds ready_out directly: a same-cycle pop frees room for the next word.
      ready_o = rst_n && !is_flush &&
                ((fill < OUT_F) || (((fill - OUT_F) < OUT_F) && bus.ready_in));
   end

   assign in_fire  = bus.valid_in && ready_o;
   assign out_fire = valid_o && bus.ready_in;

   // The buffer is always zero above fill, so appending is a plain OR at the new fill point.
   always_comb begin
      pop_buf  = out_fire ? (bit_buf >> OUT_WIDTH) : bit_buf;
      pop_fill = out_fire ? (fill - OUT_F) : fill;
      add_fill = word_bits(bus.eop_in, bus.nbits_in);
      app_buf  = pop_buf | (BUF_W'(keep_low(bus.data_in, add_fill)) << pop_fill);
   end

   assign bus.ready_out = ready_o;
   assign bus.valid_out = valid_o;
   assign bus.data_out  = bit_buf[OUT_WIDTH-1:0];
   assign bus.sop_out   = valid_o && sop_pend;
   assign bus.eop_out   = valid_o && is_flush && last_sym;
   assign bus.drop_err  = drop_err_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FILL;
         bit_buf    <= '0;
         fill       <= '0;
         sop_pend   <= 1'b0;
         pkt_emit   <= 1'b0;
         drop_err_r <= 1'b0;
      end else begin
         drop_err_r <= 1'b0;
         if (state == S_FLUSH) begin
            // Leaving FLUSH clears the buffer so the next packet never shares bits with this one.
            if (!valid_o || (out_fire && last_sym)) begin
               state      <= S_FILL;
               fill       <= '0;
               bit_buf    <= '0;
               sop_pend   <= 1'b0;
               pkt_emit   <= 1'b0;
               drop_err_r <= !valid_o && !pkt_emit;
            end else if (out_fire) begin
               bit_buf  <= pop_buf;
               fill     <= pop_fill;
               sop_pend <= 1'b0;
               pkt_emit <= 1'b1;
            end
         end else begin
            if (in_fire) begin
               bit_buf <= app_buf;
               fill    <= pop_fill + add_fill;
               if (bus.eop_in)
                  state <= S_FLUSH;
            end else if (out_fire) begin
               bit_buf <= pop_buf;
               fill    <= pop_fill;
            end
            if (out_fire) begin
               sop_pend <= 1'b0;
               pkt_emit <= 1'b1;
            end
            if (in_fire && bus.sop_in)
               sop_pend <= 1'b1;
         end
      end
   end
endmodule

// File: doc/gearbox_unpack.md
GEARBOX_UNPACK -- requirements
Module: gearbox_unpack

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 32, input word width in bits.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 7, output symbol width; legal range 1..IN_WIDTH.
REQ-003 The block SHALL have parameter PAD_LAST, default 1; 1 = zero-pad and emit a trailing partial symbol, 0 = drop it.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port valid_in, input, 1: input word valid.
REQ-007 Port ready_out, output, 1: the block can accept an input word.
REQ-008 Port data_in, input, IN_WIDTH: input word, consumed LSB first.
REQ-009 Port sop_in / eop_in, input, 1 each: first / last word of a packet.
REQ-010 Port nbits_in, input, $clog2(IN_WIDTH+1): valid bits in the eop word; sampled only with eop_in; 0 means IN_WIDTH.
REQ-011 Port valid_out, output, 1: output symbol valid.
REQ-012 Port ready_in, input, 1: downstream accepts the symbol.
REQ-013 Port data_out, output, OUT_WIDTH: output symbol.
REQ-014 Port sop_out / eop_out, output, 1 each: first / last symbol of a packet; qualified by valid_out.
REQ-015 Port drop_err, output, 1: one-cycle pulse when a packet produces no symbols.

Function
REQ-016 The block SHALL hold an LSB-first bit buffer of IN_WIDTH+OUT_WIDTH-1 bits plus a fill count.
REQ-017 An input transfer SHALL occur when valid_in and ready_out are both high; an output transfer SHALL occur when valid_out and ready_in are both high.
REQ-018 An accepted word SHALL be appended at bit position fill, after any same-cycle output pop; fill SHALL increase by IN_WIDTH, or by nbits_in on eop (0 counts as IN_WIDTH).
REQ-019 data_out SHALL equal buffer[OUT_WIDTH-1:0]; an output transfer SHALL shift the buffer right by OUT_WIDTH and decrease fill by OUT_WIDTH.
REQ-020 The block SHALL have two states, FILL and FLUSH; reset SHALL enter FILL; accepting an eop word SHALL enter FLUSH.
REQ-021 In FILL, valid_out SHALL be high when fill >= OUT_WIDTH.
REQ-022 In FILL, ready_out SHALL be high when fill < OUT_WIDTH, or when fill < 2*OUT_WIDTH and ready_in is high; this is a documented combinational ready_in-to-ready_out path.
REQ-023 In FLUSH, ready_out SHALL be 0; valid_out SHALL be high when fill >= OUT_WIDTH, or when 0 < fill < OUT_WIDTH and PAD_LAST=1.
REQ-024 The padded symbol SHALL have zeros above bit fill-1.
REQ-025 FLUSH SHALL return to FILL with fill=0 when either: the last symbol is transferred, or fill < OUT_WIDTH and PAD_LAST=0 (residual bits discarded, no symbol).
REQ-026 sop_out SHALL be high on the first symbol after an accepted sop_in word, and eop_out SHALL be high on the final symbol emitted in FLUSH.
REQ-027 When sop_out and eop_out both apply to the same symbol, both SHALL be high.
REQ-028 If FLUSH ends having emitted no symbol for the packet, drop_err SHALL pulse for one cycle and no sop_out/eop_out SHALL be produced for that packet.
REQ-029 Symbols from different packets SHALL never share bits.
REQ-030 Output SHALL be held stable while valid_out=1 and ready_in=0.
REQ-031 Latency: a symbol completed by an input word SHALL appear on valid_out the cycle after acceptance.
REQ-032 Steady-state throughput SHALL be one symbol per cycle.
REQ-033 sop_in on a word mid-packet SHALL restart sop tracking without discarding buffered bits.
REQ-034 The design SHALL be synthesizable for any legal parameter combination.

Reset
REQ-035 While rst_n=0: valid_out=0, data_out=0, sop_out=0, eop_out=0, drop_err=0, ready_out=0, fill=0, state=FILL.
REQ-036 Reset asserted mid-packet SHALL discard all buffered bits; ready_out SHALL go high the first cycle after rst_n rises.

Verification (IN_WIDTH=32, OUT_WIDTH=7)
REQ-037 One word 0xFFFF_FFFF, sop+eop, nbits=0, PAD_LAST=1, ready_in=1 -> 5 symbols: 0x7F x4 then 0x0F; sop_out on symbol 1, eop_out on symbol 5.
REQ-038 Same stimulus with PAD_LAST=0 -> 4 symbols 0x7F; eop_out on symbol 4; bits 31:28 discarded.
REQ-039 Two-word packet 64 bits, PAD_LAST=1 -> 10 symbols, the tenth = 0x01 carrying bit 63, and no gaps on valid_out after the first symbol.
REQ-040 ready_in held 0 during continuous input -> ready_out drops once fill >= 7; data_out stable; no bits lost on release.
REQ-041 One word sop+eop, nbits=5, PAD_LAST=0 -> no valid_out; drop_err pulses 1 cycle; next packet unaffected.
REQ-042 rst_n pulsed low after 3 of 5 symbols -> outputs 0 asynchronously; the next packet starts clean with sop_out on its first symbol.
